// File: rtl/serial_frame_packer.sv
// serial_frame_packer
//   Deserialises a handshaked serial bit stream into 3-bit frames {A,B,C}.
//   Each frame is presented on registered outputs with a valid/ready handshake.
//   The packer holds two partial bits plus one complete frame, so back-to-back
//   streaming into a ready consumer runs without bubbles.
//
//   Optional feature (compile-time macro PARITY_TAG_EN):
//     defined   -> adds output frame_par = ~(A^B^C). It is registered at frame
//                  load and resets to 1.
//     undefined -> frame_par port and register are absent.
//
//   state | meaning
//   ------+---------------------------------------------
//   S0    | no partial bits held
//   S1    | one partial bit held in sh[0]
//   S2    | two partial bits held (sh[1] first, sh[0] second)
module serial_frame_packer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [CNT_W-1:0] frame_cnt
`ifdef PARITY_TAG_EN
  ,
  output logic             frame_par
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] sh;
  logic       acc;
  logic       hs;
  logic       out_free;
  logic       load;
  logic [2:0] frame_next;

  // The output slot can take a new frame if it is empty or is being drained this cycle.
  assign out_free  = ~frame_valid | frame_ready;
  // A third bit is only taken when the completed frame has somewhere to go.
  assign sin_ready = ~rst & ~clr & ((state != S2) | out_free);
  assign acc       = sin_valid & sin_ready;
  assign hs        = frame_valid & frame_ready;
  assign load      = acc & (state == S2);

  // sh[1] holds the first-arrived bit, sh[0] the second, sin is the third.
  assign frame_next = MSB_FIRST ? {sh[1], sh[0], sin} : {sin, sh[0], sh[1]};

  // Bit collection FSM, output frame register and handoff counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S0;
      sh          <= 2'b00;
      A           <= 1'b0;
      B           <= 1'b0;
      C           <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
`ifdef PARITY_TAG_EN
      frame_par   <= 1'b1;
`endif
    end else begin
      // clr blocks acceptance, so it never races with a bit being shifted in.
      if (clr) begin
        state <= S0;
        sh    <= 2'b00;
      end else if (acc) begin
        case (state)
          S0: begin
            sh    <= {sh[0], sin};
            state <= S1;
          end
          S1: begin
            sh    <= {sh[0], sin};
            state <= S2;
          end
          S2: begin
            sh    <= 2'b00;
            state <= S0;
          end
          default: begin
            sh    <= 2'b00;
            state <= S0;
          end
        endcase
      end

      // A load during a handshake replaces the outgoing frame; valid stays high.
      if (load) begin
        {A, B, C}   <= frame_next;
        frame_valid <= 1'b1;
`ifdef PARITY_TAG_EN
        frame_par   <= ~(^frame_next);
`endif
      end else if (hs) begin
        frame_valid <= 1'b0;
      end

      if (hs) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
